// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the PC interrupt interface: next-address select codes, vector addresses
// and the in-service level encoding (state value == {ISR1,ISR0}).
package interrupt_controller_pkg;

  localparam logic [2:0] PC_NEXTX_NEXT  = 3'd0;
  localparam logic [2:0] PC_NEXTX_INTV0 = 3'd1;
  localparam logic [2:0] PC_NEXTX_INTV1 = 3'd2;
  localparam logic [2:0] PC_NEXTX_INTR0 = 3'd3;
  localparam logic [2:0] PC_NEXTX_INTR1 = 3'd4;

  localparam logic [15:0] INTV0 = 16'h0004;
  localparam logic [15:0] INTV1 = 16'h0008;

  typedef enum logic [1:0] {
    LVL_IDLE = 2'b00,
    LVL_IN0  = 2'b01,
    LVL_IN1  = 2'b10,
    LVL_BOTH = 2'b11
  } lvl_e;

endpackage

// File: rtl/interrupt_controller_if.sv
// Fetch-side bundle between decoder/program counter (master) and interrupt controller (slave).
interface interrupt_controller_if;
  logic       FETCH;
  logic       PC_ENX;
  logic       EI;
  logic       DI;
  logic       RETI;
  logic [2:0] PC_NEXTX;
  logic       PC_LD_INT0X;
  logic       PC_LD_INT1X;
  logic [1:0] INT_ACK;
  logic [1:0] INT_ISR;
  logic       INT_IE;

  modport master (
    output FETCH, PC_ENX, EI, DI, RETI,
    input  PC_NEXTX, PC_LD_INT0X, PC_LD_INT1X, INT_ACK, INT_ISR, INT_IE
  );

  modport slave (
    input  FETCH, PC_ENX, EI, DI, RETI,
    output PC_NEXTX, PC_LD_INT0X, PC_LD_INT1X, INT_ACK, INT_ISR, INT_IE
  );
endinterface

// File: rtl/intc_sync_edge.sv
// Synchronises one asynchronous request line through SYNC_STAGES flops and emits a one-cycle
// pulse on each rising edge of the synchronised level.
module intc_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic req_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
      lvl_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  // Held-high lines produce a single pulse; reset clears lvl_q so a line high at release counts once.
  assign rise_o = sync_q[SYNC_STAGES-1] & ~lvl_q;

endmodule

// File: rtl/interrupt_controller.sv
// Two-level prioritised interrupt requester (INT0 > INT1) driving PC vector/return selects on FETCH.
// Define INTC_NESTING_EN to let INT0 preempt an in-service INT1.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   INT0_REQ,
  input  logic                   INT1_REQ,
  interrupt_controller_if.slave  bus
);

  logic [1:0] rise;
  logic [1:0] pend_q, pend_d;
  logic [1:0] taken;
  logic       ie_q, ie_d;
  lvl_e       lvl_q, lvl_d;
  logic       qual;
  logic       take0;
  logic [2:0] nextx;
  logic       ld0, ld1;
  logic [1:0] ack;

  intc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (
    .CLK    (CLK),
    .RESETN (RESETN),
    .req_i  (INT0_REQ),
    .rise_o (rise[0])
  );

  intc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
    .CLK    (CLK),
    .RESETN (RESETN),
    .req_i  (INT1_REQ),
    .rise_o (rise[1])
  );

  assign qual = bus.FETCH & bus.PC_ENX;

`ifdef INTC_NESTING_EN
  assign take0 = ~lvl_q[0];
`else
  assign take0 = (lvl_q == LVL_IDLE);
`endif

  always_comb begin
    nextx = PC_NEXTX_NEXT;
    ld0   = 1'b0;
    ld1   = 1'b0;
    ack   = 2'b00;
    taken = 2'b00;
    lvl_d = lvl_q;
    if (qual) begin
      if (bus.RETI) begin
        // Innermost level (INT0) unwinds first; RETI with nothing in service is ignored.
        case (lvl_q)
          LVL_IN0: begin
            nextx = PC_NEXTX_INTR0;
            lvl_d = LVL_IDLE;
          end
          LVL_BOTH: begin
            nextx = PC_NEXTX_INTR0;
            lvl_d = LVL_IN1;
          end
          LVL_IN1: begin
            nextx = PC_NEXTX_INTR1;
            lvl_d = LVL_IDLE;
          end
          default: ;
        endcase
      end else if (ie_q && pend_q[0] && take0) begin
        nextx    = PC_NEXTX_INTV0;
        ld0      = 1'b1;
        ack[0]   = 1'b1;
        taken[0] = 1'b1;
        lvl_d    = (lvl_q == LVL_IN1) ? LVL_BOTH : LVL_IN0;
      end else if (ie_q && pend_q[1] && (lvl_q == LVL_IDLE)) begin
        nextx    = PC_NEXTX_INTV1;
        ld1      = 1'b1;
        ack[1]   = 1'b1;
        taken[1] = 1'b1;
        lvl_d    = LVL_IN1;
      end
    end
  end

  // A fresh edge in the same cycle as the take re-arms the pending bit.
  assign pend_d = rise | (pend_q & ~taken);
  assign ie_d   = bus.DI ? 1'b0 : (bus.EI ? 1'b1 : ie_q);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pend_q <= 2'b00;
      ie_q   <= 1'b0;
      lvl_q  <= LVL_IDLE;
    end else begin
      pend_q <= pend_d;
      ie_q   <= ie_d;
      lvl_q  <= lvl_d;
    end
  end

  assign bus.PC_NEXTX    = nextx;
  assign bus.PC_LD_INT0X = ld0;
  assign bus.PC_LD_INT1X = ld1;
  assign bus.INT_ACK     = ack;
  assign bus.INT_ISR     = lvl_q;
  assign bus.INT_IE      = ie_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: entry, priority, nesting, enable, RETI and reset cases.
module tb_interrupt_controller;

  localparam int P = 2;

  logic CLK      = 1'b0;
  logic RESETN   = 1'b0;
  logic INT0_REQ = 1'b0;
  logic INT1_REQ = 1'b0;
  int   n_chk    = 0;
  int   n_pass   = 0;

  interrupt_controller_if bus ();

  interrupt_controller #(.SYNC_STAGES(P)) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .INT0_REQ (INT0_REQ),
    .INT1_REQ (INT1_REQ),
    .bus      (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // One qualifying fetch: checks combinational outputs, then the ISR level after the edge.
  task automatic fetch(input string tag, input logic reti, input logic [2:0] nx,
                       input logic [1:0] ld, input logic [1:0] ack, input logic [1:0] isr);
    bus.FETCH  = 1'b1;
    bus.PC_ENX = 1'b1;
    bus.RETI   = reti;
    #1;
    chk({tag, "_nx"},  8'(bus.PC_NEXTX), 8'(nx));
    chk({tag, "_ld"},  8'({bus.PC_LD_INT1X, bus.PC_LD_INT0X}), 8'(ld));
    chk({tag, "_ack"}, 8'(bus.INT_ACK), 8'(ack));
    tick;
    bus.FETCH  = 1'b0;
    bus.PC_ENX = 1'b0;
    bus.RETI   = 1'b0;
    #1;
    chk({tag, "_isr"}, 8'(bus.INT_ISR), 8'(isr));
  endtask

  task automatic pulse(input logic ei, input logic di);
    bus.EI = ei;
    bus.DI = di;
    tick;
    bus.EI = 1'b0;
    bus.DI = 1'b0;
  endtask

  // Drop the selected lines long enough to clear the synchroniser, then raise them until pending.
  task automatic new_edges(input logic l0, input logic l1);
    if (l0) INT0_REQ = 1'b0;
    if (l1) INT1_REQ = 1'b0;
    repeat (P + 1) tick;
    if (l0) INT0_REQ = 1'b1;
    if (l1) INT1_REQ = 1'b1;
    repeat (P + 1) tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic found;
    int   acks;
    bus.FETCH  = 1'b0;
    bus.PC_ENX = 1'b0;
    bus.EI     = 1'b0;
    bus.DI     = 1'b0;
    bus.RETI   = 1'b0;
    #3;
    chk("rst_nx",  8'(bus.PC_NEXTX), 8'd0);
    chk("rst_ld",  8'({bus.PC_LD_INT1X, bus.PC_LD_INT0X}), 8'd0);
    chk("rst_ack", 8'(bus.INT_ACK), 8'd0);
    chk("rst_isr", 8'(bus.INT_ISR), 8'd0);
    chk("rst_ie",  8'(bus.INT_IE), 8'd0);
    #9 RESETN = 1'b1;
    tick;

    // INT1 entry with FETCH held, bounded by SYNC_STAGES+2 clocks
    pulse(1'b1, 1'b0);
    chk("t1_ie", 8'(bus.INT_IE), 8'd1);
    INT1_REQ   = 1'b1;
    bus.FETCH  = 1'b1;
    bus.PC_ENX = 1'b1;
    #1;
    found = 1'b0;
    for (int i = 0; i < P + 3 && !found; i++) begin
      if (bus.PC_LD_INT1X) found = 1'b1;
      else tick;
    end
    chk("t1_found", 8'(found), 8'd1);
    chk("t1_nx",  8'(bus.PC_NEXTX), 8'd2);
    chk("t1_ack", 8'(bus.INT_ACK), 8'b10);
    tick;
    bus.FETCH  = 1'b0;
    bus.PC_ENX = 1'b0;
    #1;
    chk("t1_isr", 8'(bus.INT_ISR), 8'b10);
    chk("t1_ack_idle", 8'(bus.INT_ACK), 8'd0);
    fetch("t1_reti", 1'b1, 3'd4, 2'b00, 2'b00, 2'b00);

    // Both pending: INT0 first, INT1 after RETI
    new_edges(1'b1, 1'b1);
    fetch("t2_int0", 1'b0, 3'd1, 2'b01, 2'b01, 2'b01);
    fetch("t2_hold", 1'b0, 3'd0, 2'b00, 2'b00, 2'b01);
    fetch("t2_reti", 1'b1, 3'd3, 2'b00, 2'b00, 2'b00);
    fetch("t2_int1", 1'b0, 3'd2, 2'b10, 2'b10, 2'b10);

    // INT0 edge while INT1 in service
    new_edges(1'b1, 1'b0);
`ifdef INTC_NESTING_EN
    fetch("t3_pre",  1'b0, 3'd1, 2'b01, 2'b01, 2'b11);
    fetch("t3_r0",   1'b1, 3'd3, 2'b00, 2'b00, 2'b10);
    fetch("t3_r1",   1'b1, 3'd4, 2'b00, 2'b00, 2'b00);
`else
    fetch("t3_blk",  1'b0, 3'd0, 2'b00, 2'b00, 2'b10);
    fetch("t3_r1",   1'b1, 3'd4, 2'b00, 2'b00, 2'b00);
    fetch("t3_int0", 1'b0, 3'd1, 2'b01, 2'b01, 2'b01);
    fetch("t3_r0",   1'b1, 3'd3, 2'b00, 2'b00, 2'b00);
`endif

    // Global enable
    pulse(1'b0, 1'b1);
    chk("t4_di", 8'(bus.INT_IE), 8'd0);
    new_edges(1'b1, 1'b0);
    fetch("t4_off", 1'b0, 3'd0, 2'b00, 2'b00, 2'b00);
    pulse(1'b1, 1'b0);
    chk("t4_ei", 8'(bus.INT_IE), 8'd1);
    fetch("t4_on",   1'b0, 3'd1, 2'b01, 2'b01, 2'b01);
    fetch("t4_reti", 1'b1, 3'd3, 2'b00, 2'b00, 2'b00);
    pulse(1'b1, 1'b1);
    chk("t4_both", 8'(bus.INT_IE), 8'd0);
    pulse(1'b1, 1'b0);
    chk("t4_reen", 8'(bus.INT_IE), 8'd1);

    // RETI beats a pending INT0 entry; spurious RETI
    new_edges(1'b0, 1'b1);
    fetch("t5_in1",  1'b0, 3'd2, 2'b10, 2'b10, 2'b10);
    new_edges(1'b1, 1'b0);
    fetch("t5_reti", 1'b1, 3'd4, 2'b00, 2'b00, 2'b00);
    fetch("t5_int0", 1'b0, 3'd1, 2'b01, 2'b01, 2'b01);
    fetch("t5_r0",   1'b1, 3'd3, 2'b00, 2'b00, 2'b00);
    fetch("t5_spur", 1'b1, 3'd0, 2'b00, 2'b00, 2'b00);

    // INT0 still held high: no further entries
    fetch("t6_held_a", 1'b0, 3'd0, 2'b00, 2'b00, 2'b00);
    fetch("t6_held_b", 1'b0, 3'd0, 2'b00, 2'b00, 2'b00);

    // Asynchronous reset while in service
    new_edges(1'b0, 1'b1);
    fetch("t6_in1", 1'b0, 3'd2, 2'b10, 2'b10, 2'b10);
`ifdef INTC_NESTING_EN
    new_edges(1'b1, 1'b0);
    fetch("t6_both", 1'b0, 3'd1, 2'b01, 2'b01, 2'b11);
`endif
    INT1_REQ   = 1'b0;
    bus.FETCH  = 1'b1;
    bus.PC_ENX = 1'b1;
    bus.RETI   = 1'b1;
    #1;
`ifdef INTC_NESTING_EN
    chk("t6_pre_nx", 8'(bus.PC_NEXTX), 8'd3);
`else
    chk("t6_pre_nx", 8'(bus.PC_NEXTX), 8'd4);
`endif
    RESETN = 1'b0;
    #1;
    chk("t6_rst_isr", 8'(bus.INT_ISR), 8'd0);
    chk("t6_rst_ie",  8'(bus.INT_IE), 8'd0);
    chk("t6_rst_nx",  8'(bus.PC_NEXTX), 8'd0);
    bus.FETCH  = 1'b0;
    bus.PC_ENX = 1'b0;
    bus.RETI   = 1'b0;
    #1 RESETN = 1'b1;
    tick;

    // Held-high INT0 after reset yields exactly one acknowledge
    INT0_REQ = 1'b1;
    pulse(1'b1, 1'b0);
    bus.FETCH  = 1'b1;
    bus.PC_ENX = 1'b1;
    #1;
    acks = 0;
    for (int i = 0; i < 2 * P + 6; i++) begin
      if (bus.INT_ACK[0]) acks++;
      tick;
    end
    bus.FETCH  = 1'b0;
    bus.PC_ENX = 1'b0;
    #1;
    chk("t6_one_ack", 8'(acks), 8'd1);
    chk("t6_end_isr", 8'(bus.INT_ISR), 8'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
